// File: rtl/neperek_ctrl.sv
// -----------------------------------------------------------------------------
// neperek_ctrl
//
// Two-requester front end for a serial sequence detector. A round-robin arbiter
// accepts one W-bit word at a time, shifts it MSB first onto INP (one bit per
// cycle), waits one drain cycle to pick up the lagging Moore flag, then holds
// a result (requester index, Moore and Mealy detection counts) until the
// consumer takes it.
//
// Ports
//   clk            rising-edge clock
//   nres           asynchronous active-low reset
//   req0_valid     requester 0 has a word pending
//   req0_data      requester 0 word (W bits, shifted MSB first)
//   req0_ready     requester 0 word accepted this cycle (with req0_valid)
//   req1_valid     requester 1 has a word pending
//   req1_data      requester 1 word
//   req1_ready     requester 1 word accepted this cycle (with req1_valid)
//   INP            serial bit to the detector
//   OUT_MOORE      Moore detect flag from the detector
//   OUT_MEALY      Mealy detect flag from the detector
//   res_valid      result available
//   res_id         requester index of the result
//   res_moore_cnt  saturating Moore detection count for the word
//   res_mealy_cnt  saturating Mealy detection count for the word
//   res_ready      result consumer accepts (with res_valid)
//   busy           high whenever the controller is not idle
// -----------------------------------------------------------------------------
module neperek_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          nres,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          INP,
  input  logic          OUT_MOORE,
  input  logic          OUT_MEALY,
  output logic          res_valid,
  output logic          res_id,
  output logic [CW-1:0] res_moore_cnt,
  output logic [CW-1:0] res_mealy_cnt,
  input  logic          res_ready,
  output logic          busy
);

  localparam int            BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [W-1:0]  shift_r;
  logic [BW-1:0] bit_r;
  logic [CW-1:0] moore_r;
  logic [CW-1:0] mealy_r;
  logic          id_r;
  logic          last_grant_r;
  logic          grant_s;
  logic          accept_s;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CW'(1);
    end
  endfunction

  // Round-robin arbiter: a lone requester wins; on a tie the requester that
  // was not granted last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // A word is taken only from IDLE, and only when somebody is asking.
  always_comb begin
    accept_s = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = req0_valid | req1_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_r == LAST_BIT) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        state_s = ST_REPORT;
      end
      ST_REPORT: begin
        // res_valid is high throughout REPORT, so res_ready alone completes it.
        if (res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs. Ready is forced low while nres is asserted so that no
  // handshake can appear during reset even though the state already reads
  // IDLE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (nres && accept_s) begin
      req0_ready = ~grant_s;
      req1_ready = grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    busy      = (state_r != ST_IDLE);
    res_valid = (state_r == ST_REPORT);
  end

  // Word capture and MSB-first shifter. Zeros are shifted in, so after W
  // shifts the register is empty and INP is naturally 0 in DRAIN, REPORT and
  // IDLE without extra gating.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      shift_r      <= '0;
      bit_r        <= '0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shift_r      <= grant_s ? req1_data : req0_data;
            bit_r        <= '0;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
          end else begin
            shift_r <= shift_r;
          end
        end
        ST_SHIFT: begin
          shift_r <= shift_r << 1;
          bit_r   <= bit_r + BW'(1);
        end
        default: begin
          shift_r <= shift_r;
        end
      endcase
    end
  end

  // Detection counters. The Moore flag lags its bit by one cycle, so it is
  // ignored on bit 0 (it belongs to the previous word) and sampled once more
  // in DRAIN for the last bit.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      moore_r <= '0;
      mealy_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            moore_r <= '0;
            mealy_r <= '0;
          end else begin
            moore_r <= moore_r;
          end
        end
        ST_SHIFT: begin
          if (OUT_MEALY) begin
            mealy_r <= sat_inc(mealy_r);
          end else begin
            mealy_r <= mealy_r;
          end
          if (OUT_MOORE && (bit_r != '0)) begin
            moore_r <= sat_inc(moore_r);
          end else begin
            moore_r <= moore_r;
          end
        end
        ST_DRAIN: begin
          if (OUT_MOORE) begin
            moore_r <= sat_inc(moore_r);
          end else begin
            moore_r <= moore_r;
          end
        end
        default: begin
          moore_r <= moore_r;
        end
      endcase
    end
  end

  assign INP           = shift_r[W-1];
  assign res_id        = id_r;
  assign res_moore_cnt = moore_r;
  assign res_mealy_cnt = mealy_r;

endmodule

// File: tb/tb_neperek_ctrl.sv
// -----------------------------------------------------------------------------
// tb_neperek_ctrl
//
// Directed bench for neperek_ctrl. A behavioural "0001" detector (enabled
// while the controller shifts or drains) closes the loop on the main
// instance; a second instance with CW=1 has both detector flags tied high.
// Expected results are predicted when a word is offered and queued, then
// compared when the result handshake happens.
// -----------------------------------------------------------------------------
module tb_neperek_ctrl;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          nres;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_data, req1_data;
  logic          inp, out_moore, out_mealy;
  logic          res_valid, res_id, res_ready, busy;
  logic [CW-1:0] res_moore_cnt, res_mealy_cnt;

  logic          b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [W-1:0]  b_req0_data, b_req1_data;
  logic          b_inp, b_res_valid, b_res_id, b_res_ready, b_busy;
  logic [0:0]    b_moore_cnt, b_mealy_cnt;

  typedef struct packed {
    logic          id;
    logic [CW-1:0] moore;
    logic [CW-1:0] mealy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;
  int   model_zc;

  neperek_ctrl #(.W(W), .CW(CW)) u_dut (
    .clk(clk), .nres(nres),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .INP(inp), .OUT_MOORE(out_moore), .OUT_MEALY(out_mealy),
    .res_valid(res_valid), .res_id(res_id),
    .res_moore_cnt(res_moore_cnt), .res_mealy_cnt(res_mealy_cnt),
    .res_ready(res_ready), .busy(busy)
  );

  neperek_ctrl #(.W(W), .CW(1)) u_sat (
    .clk(clk), .nres(nres),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .INP(b_inp), .OUT_MOORE(1'b1), .OUT_MEALY(1'b1),
    .res_valid(b_res_valid), .res_id(b_res_id),
    .res_moore_cnt(b_moore_cnt), .res_mealy_cnt(b_mealy_cnt),
    .res_ready(b_res_ready), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment "0001" detector: counts trailing zeros, Mealy flag on the
  // completing 1, Moore flag one cycle later.
  logic [1:0] det_zc;
  logic       det_found;
  logic       det_en;
  assign det_en    = busy && !res_valid;
  assign out_mealy = det_en && inp && (det_zc == 2'd3);
  assign out_moore = det_found;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      det_zc    <= 2'd0;
      det_found <= 1'b0;
    end else if (det_en) begin
      if (inp) begin
        det_found <= (det_zc == 2'd3);
        det_zc    <= 2'd0;
      end else begin
        det_found <= 1'b0;
        if (det_zc != 2'd3) det_zc <= det_zc + 2'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the counts for one word: detector runs over W bits plus the drain
  // zero, Moore ignored on bit 0, both counts saturating.
  function automatic exp_t predict(input logic [W-1:0] word);
    exp_t r;
    int   zc = model_zc;
    bit   found = 1'b0;
    int   mo = 0;
    int   me = 0;
    bit   b;
    for (int i = 0; i < W; i++) begin
      b = word[W-1-i];
      if (b && zc == 3 && me < MAXC) me++;
      if (i >= 1 && found && mo < MAXC) mo++;
      if (b) begin
        found = (zc == 3);
        zc = 0;
      end else begin
        found = 1'b0;
        zc = (zc < 3) ? zc + 1 : 3;
      end
    end
    if (found && mo < MAXC) mo++;
    zc = (zc < 3) ? zc + 1 : 3;
    model_zc = zc;
    r.id    = 1'b0;
    r.moore = CW'(mo);
    r.mealy = CW'(me);
    return r;
  endfunction

  // Serve one word from IDLE: grant, serial bits, drain, report with an
  // optional hold, handshake, back to IDLE.
  task automatic serve(input logic exp_id, input int hold, input bit keep);
    logic [W-1:0] word;
    exp_t         e;
    word = exp_id ? req1_data : req0_data;
    #1;
    chk("grant_ready0", 32'(req0_ready), {31'd0, ~exp_id});
    chk("grant_ready1", 32'(req1_ready), {31'd0, exp_id});
    e = predict(word);
    e.id = exp_id;
    sb_q.push_back(e);
    tick();
    if (!keep) begin
      if (exp_id) req1_valid = 1'b0;
      else        req0_valid = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      #1;
      chk("shift_inp", 32'(inp), 32'(word[W-1-i]));
      chk("shift_busy", 32'(busy), 32'd1);
      if (i == 0) begin
        chk("shift_ready0", 32'(req0_ready), 32'd0);
        chk("shift_ready1", 32'(req1_ready), 32'd0);
      end
      tick();
    end
    #1;
    chk("drain_inp", 32'(inp), 32'd0);
    chk("drain_res_valid", 32'(res_valid), 32'd0);
    tick();
    for (int j = 0; j < hold; j++) begin
      #1;
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_id", 32'(res_id), 32'(sb_q[0].id));
      chk("hold_moore", 32'(res_moore_cnt), 32'(sb_q[0].moore));
      chk("hold_mealy", 32'(res_mealy_cnt), 32'(sb_q[0].mealy));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_ready0", 32'(req0_ready), 32'd0);
      chk("hold_ready1", 32'(req1_ready), 32'd0);
      chk("hold_inp", 32'(inp), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("res_valid", 32'(res_valid), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("res_id", 32'(res_id), 32'(e.id));
      chk("res_moore_cnt", 32'(res_moore_cnt), 32'(e.moore));
      chk("res_mealy_cnt", 32'(res_mealy_cnt), 32'(e.mealy));
    end else begin
      n_errors++;
      $display("FAIL scoreboard: observed empty queue expected one entry");
    end
    tick();
    res_ready = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_zc = 0;
    nres = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    res_ready = 1'b0;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    b_req0_data = 8'h00; b_req1_data = 8'h00;
    b_res_ready = 1'b1;
    tick();
    tick();

    // Reset state, with a request pending to show ready stays low.
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inp", 32'(inp), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_moore", 32'(res_moore_cnt), 32'd0);
    chk("rst_mealy", 32'(res_mealy_cnt), 32'd0);
    chk("rst_sat_busy", 32'(b_busy), 32'd0);
    req0_valid = 1'b0;
    tick();
    nres = 1'b1;
    tick();

    // 00010001 from requester 0: two Mealy and two Moore hits.
    req0_data = 8'b0001_0001; req0_valid = 1'b1;
    serve(1'b0, 0, 1'b0);

    // All ones, then all zeros: no hits.
    req1_data = 8'hFF; req1_valid = 1'b1;
    serve(1'b1, 1, 1'b0);
    req0_data = 8'h00; req0_valid = 1'b1;
    serve(1'b0, 0, 1'b0);

    // Tie after a requester-0 grant goes to requester 1; report held 5 cycles
    // while requester 0 keeps asking; requester 0 then served.
    req0_data = 8'h33; req0_valid = 1'b1;
    req1_data = 8'h5A; req1_valid = 1'b1;
    serve(1'b1, 5, 1'b0);
    serve(1'b0, 0, 1'b0);

    // Reset during bit 4 of a word: everything drops at once, no result.
    req0_data = 8'b0000_1000; req0_valid = 1'b1;
    #1;
    chk("mid_ready0", 32'(req0_ready), 32'd1);
    tick();
    repeat (4) tick();
    #1;
    chk("mid_inp_before", 32'(inp), 32'd1);
    nres = 1'b0;
    #1;
    chk("mid_rst_inp", 32'(inp), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
    chk("mid_rst_mealy", 32'(res_mealy_cnt), 32'd0);
    model_zc = 0;
    tick();
    req0_valid = 1'b0;
    nres = 1'b1;
    tick();

    // Tie after reset: 0, then 1, then 0 again while both stay valid.
    req0_data = 8'b0001_0001; req0_valid = 1'b1;
    req1_data = 8'hC3;        req1_valid = 1'b1;
    serve(1'b0, 0, 1'b1);
    serve(1'b1, 0, 1'b1);
    serve(1'b0, 0, 1'b0);
    serve(1'b1, 2, 1'b0);

    // CW=1 instance with both flags forced high: counts saturate at 1.
    b_req0_data = 8'h00; b_req0_valid = 1'b1;
    #1;
    chk("sat_ready0", 32'(b_req0_ready), 32'd1);
    chk("sat_ready1", 32'(b_req1_ready), 32'd0);
    tick();
    b_req0_valid = 1'b0;
    repeat (W + 1) tick();
    #1;
    chk("sat_res_valid", 32'(b_res_valid), 32'd1);
    chk("sat_res_id", 32'(b_res_id), 32'd0);
    chk("sat_moore", 32'(b_moore_cnt), 32'd1);
    chk("sat_mealy", 32'(b_mealy_cnt), 32'd1);
    chk("sat_inp", 32'(b_inp), 32'd0);
    tick();
    #1;
    chk("sat_idle_busy", 32'(b_busy), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/neperek_ctrl.md
NEPEREK_CTRL -- requirements
Module: neperek_ctrl

Interface
REQ-001 Parameter W, default 8, meaning bits per request word shifted into the detector.
REQ-002 Parameter CW, default 4, meaning width of each detection counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 nres  input  1  reset, asynchronous and active-low.
REQ-005 req0_valid  input  1  requester 0 has a word pending.
REQ-006 req0_data  input  W  requester 0 word, shifted MSB first.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_data, req1_ready  same widths and directions as requester 0, for requester 1.
REQ-009 INP  output  1  serial bit to the sequence detector.
REQ-010 OUT_MOORE  input  1  Moore detect flag from the detector.
REQ-011 OUT_MEALY  input  1  Mealy detect flag from the detector.
REQ-012 res_valid  output  1  result available.
REQ-013 res_id  output  1  requester index the result belongs to.
REQ-014 res_moore_cnt  output  CW  Moore detections counted for the word.
REQ-015 res_mealy_cnt  output  CW  Mealy detections counted for the word.
REQ-016 res_ready  input  1  result consumer accepts when high with res_valid.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, SHIFT, DRAIN, REPORT; IDLE -> SHIFT on accepted word; SHIFT -> DRAIN after W bits; DRAIN -> REPORT after 1 cycle; REPORT -> IDLE on res_valid && res_ready.
REQ-019 reqN_ready asserted combinationally only in IDLE, only for the granted requester; never both high.
REQ-020 Arbitration round-robin: one valid requester -> grant it; both valid -> grant the one not granted last; last-grant pointer updates only on an accepted word.
REQ-021 Accepted word latched into a W-bit shift register with res_id = granted index; counters cleared to 0 on the same edge.
REQ-022 In SHIFT, INP = current MSB of shift register for exactly W cycles, bit index 0..W-1, one bit per cycle, MSB first.
REQ-023 INP = 0 in IDLE, DRAIN, REPORT and reset.
REQ-024 Mealy counter increments in every SHIFT cycle with OUT_MEALY = 1.
REQ-025 Moore counter increments in SHIFT cycles with bit index 1..W-1 and in the DRAIN cycle when OUT_MOORE = 1 (one-cycle Moore lag).
REQ-026 Both counters saturate at 2^CW-1; no wrap-around.
REQ-027 Latency: word accepted at edge k -> first INP bit cycle k+1, DRAIN cycle k+W+1, res_valid high from cycle k+W+2.
REQ-028 In REPORT, res_valid, res_id and both counts held stable until res_ready; no new word accepted while not IDLE.
REQ-029 Handshake completing in REPORT -> IDLE next cycle; a valid request may be accepted in that IDLE cycle (one idle bubble minimum between words).
REQ-030 Detector state not cleared between words; pattern spanning word boundaries with the inserted zeros is the caller's concern.

Reset
REQ-031 nres low: state IDLE, shift register 0, counters 0, last-grant pointer = requester 1 (requester 0 wins first tie), res_id 0, all outputs 0 immediately and asynchronously.
REQ-032 Reset mid-SHIFT or mid-REPORT abandons the word with no result; after release behaviour is identical to power-up.

Verification
REQ-033 req0 word 8'b00010001 -> INP 0,0,0,1,0,0,0,1 in cycles k+1..k+8; res_id 0, res_mealy_cnt 2, res_moore_cnt 2 at k+10.
REQ-034 req0 and req1 valid on the same cycle after reset -> req0 served first, req1 next, then req0 again if still valid.
REQ-035 res_ready held low 5 cycles in REPORT -> res_valid and counts stable all 5 cycles, both reqN_ready low, busy high.
REQ-036 Word 8'hFF -> both counts 0; word 8'h00 -> both counts 0, INP 0 throughout.
REQ-037 nres pulsed low during SHIFT bit 4 -> INP, busy, res_valid 0 at once; next request served from IDLE with fresh counts.
REQ-038 CW=1, detector forced to OUT_MEALY=1 and OUT_MOORE=1 every cycle -> both counts saturate at 1.
